led_sequencer: RTL and testbench
================================

// Module: led_sequencer
// PURPOSE
//   Bus-mapped controller that sequences the board LED from a programmable bit pattern.
//   Sits on the CPU register bus alongside other peripherals and uses the same
//   address/data/rd_wr_i protocol.
//   Replaces static LED writes with timed playback: one-shot or repeating, with a programmable bit period.
// PARAMETERS
//   BaseAddress    0   first register address; the map occupies BaseAddress+0..+4
//   address_width  15  bus address width
//   data_width     16  bus data width; must be >= 8
// PORTS
//   clk_i      in   1              system clock; all state changes on its rising edge
//   reset_i    in   1              synchronous, active-high reset
//   address_i  in   address_width  register address
//   data_o     out  data_width     read data; combinational
//   data_i     in   data_width     write data
//   rd_wr_i    in   1              1 = write (sampled every clock), 0 = read
//   led_o      out  1              LED drive
// BEHAVIOUR
//   Register map (offset from BaseAddress); unused bits read as 0:
//     +0 CTRL    RW  [0] enable, [1] oneshot, [2] start (write-1 strobe; reads 0)
//     +1 DIV     RW  prescaler terminal count; each bit is held for DIV+1 clocks
//     +2 PATTERN RW  bits played LSB first
//     +3 LENGTH  RW  [$clog2(data_width):0] bit count
//                    0 or any value > data_width -> data_width
//     +4 STATUS  RO  [0] running, [1] done (sticky); writes are ignored
//   Bus:
//     - A write takes effect at the clock edge where rd_wr_i=1 and the address matches.
//     - data_o = selected register when rd_wr_i=0 and the address is mapped; otherwise 0.
//   Reset:
//     - All registers, presc, idx and the shadows clear to 0.
//     - state = IDLE, led_o = 0, data_o follows the read mux (0 for all registers).
//   Shadows: PATTERN and LENGTH are copied to shadow regs on every start and every wrap.
//     Bus writes during RUN therefore take effect only at the next start or wrap.
//   FSM IDLE / RUN / DONE:
//     Start:
//       - A CTRL write with start=1 and enable=1 from any state gives
//         state <= RUN, presc <= 0, idx <= 0, shadows loaded, done <= 0.
//       - Start with enable=0 only updates CTRL and the state is unchanged.
//     Disable:
//       - A CTRL write with enable=0 in RUN gives state <= IDLE; done is unchanged.
//       - Disable has priority over all RUN advance logic on the same edge.
//     RUN:
//       - presc increments every clock.
//       - When presc >= DIV: presc <= 0 and idx advances.
//         The >= compare makes a DIV decrease mid-bit advance on the next clock, never wrap.
//       - At idx == len-1 with oneshot=1: state <= DONE, done <= 1, running <= 0.
//       - At idx == len-1 with oneshot=0: idx <= 0 and the shadows reload.
//     DONE: led_o = 0; waits for a start.
//   led_o:
//     - led_o = pat_shadow[idx] in RUN, 0 otherwise.
//     - Driven from registered state only, so it is valid the cycle after the start edge.
//   Latency:
//     - Start-to-first-bit is 1 clock.
//     - Each bit lasts DIV+1 clocks.
//     - The one-shot pass lasts len*(DIV+1) clocks.
//   STATUS.running = (state == RUN).
//   Simultaneous events: reset_i beats every bus write; a start write beats the advance/wrap on the same edge.
// TESTING
//   T1 reset:
//     - Stimulus: pulse reset_i mid-RUN.
//     - Next cycle: led_o=0, all reads 0, STATUS=0.
//   T2 one-shot:
//     - Stimulus: PATTERN=0x0005, LENGTH=4, DIV=2, CTRL=0x7.
//     - led_o is 1,1,1,0,0,0,1,1,1,0,0,0 then 0.
//     - STATUS=0x2 from the 13th clock after the start.
//   T3 repeat + shadow:
//     - Stimulus: CTRL=0x5 with PATTERN=0x1, LENGTH=2, DIV=0; write PATTERN=0x2 mid-pass.
//     - led_o plays 1,0 until the wrap, then 0,1 repeating.
//   T4 disable mid-run:
//     - Stimulus: write CTRL=0x0 during RUN.
//     - led_o=0 and STATUS=0 the next cycle; DONE is never reached.
//   T5 DIV shrink:
//     - Stimulus: DIV=100 and presc reaches 50; write DIV=1.
//     - idx advances on the following clock, not after a counter wrap.
//   T6 LENGTH clamp:
//     - Stimulus: LENGTH=0, then LENGTH=31, with PATTERN=0xFFFF, DIV=0, oneshot.
//     - Each run gives 16 clocks of led_o=1, then DONE.

Source files
------------

// File: rtl/led_sequencer.sv
// Bus-mapped LED pattern sequencer: plays a programmable bit pattern LSB first,
// one-shot or repeating, with each bit held for DIV+1 clocks.
module led_sequencer #(
    parameter int BaseAddress   = 0,
    parameter int address_width = 15,
    parameter int data_width    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    output logic [data_width-1:0]    data_o,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic                     led_o
);
    localparam int LW = $clog2(data_width) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [address_width-1:0] A_CTRL = address_width'(BaseAddress + 0);
    localparam logic [address_width-1:0] A_DIV  = address_width'(BaseAddress + 1);
    localparam logic [address_width-1:0] A_PAT  = address_width'(BaseAddress + 2);
    localparam logic [address_width-1:0] A_LEN  = address_width'(BaseAddress + 3);
    localparam logic [address_width-1:0] A_STAT = address_width'(BaseAddress + 4);

    localparam logic [LW-1:0] FULL_LEN = LW'(data_width);

    logic                  en_q, oneshot_q, done_q;
    logic [data_width-1:0] div_q, pat_q, pat_sh, presc, pat_shift;
    logic [LW-1:0]         len_q, len_sh, idx, len_eff;
    logic [1:0]            state;
    logic                  wr_ctrl, wr_div, wr_pat, wr_len, start, disable_run, last_bit;

    assign wr_ctrl = rd_wr_i && (address_i == A_CTRL);
    assign wr_div  = rd_wr_i && (address_i == A_DIV);
    assign wr_pat  = rd_wr_i && (address_i == A_PAT);
    assign wr_len  = rd_wr_i && (address_i == A_LEN);

    assign start       = wr_ctrl && data_i[2] && data_i[0];
    assign disable_run = wr_ctrl && !data_i[0] && (state == RUN);

    // Out-of-range lengths play the whole pattern width.
    assign len_eff  = (len_q == '0 || len_q > FULL_LEN) ? FULL_LEN : len_q;
    assign last_bit = (idx == len_sh - LW'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            done_q    <= 1'b0;
            div_q     <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            pat_sh    <= '0;
            len_sh    <= '0;
            presc     <= '0;
            idx       <= '0;
            state     <= IDLE;
        end else begin
            if (wr_ctrl) begin
                en_q      <= data_i[0];
                oneshot_q <= data_i[1];
            end
            if (wr_div) div_q <= data_i;
            if (wr_pat) pat_q <= data_i;
            if (wr_len) len_q <= data_i[LW-1:0];

            if (start) begin
                state  <= RUN;
                presc  <= '0;
                idx    <= '0;
                pat_sh <= pat_q;
                len_sh <= len_eff;
                done_q <= 1'b0;
            end else if (disable_run) begin
                state <= IDLE;
            end else if (state == RUN) begin
                // >= so a DIV shrink mid-bit ends the bit next clock instead of wrapping presc
                if (presc >= div_q) begin
                    presc <= '0;
                    if (last_bit) begin
                        if (oneshot_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx    <= '0;
                            pat_sh <= pat_q;
                            len_sh <= len_eff;
                        end
                    end else begin
                        idx <= idx + LW'(1);
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign pat_shift = pat_sh >> idx;
    assign led_o     = (state == RUN) && pat_shift[0];

    always_comb begin
        data_o = '0;
        if (!rd_wr_i) begin
            case (address_i)
                A_CTRL:  data_o[1:0]    = {oneshot_q, en_q};
                A_DIV:   data_o         = div_q;
                A_PAT:   data_o         = pat_q;
                A_LEN:   data_o[LW-1:0] = len_q;
                A_STAT:  data_o[1:0]    = {done_q, state == RUN};
                default: data_o         = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: register table plus hand-timed playback sequences.
module tb_led_sequencer;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [14:0] address_i;
    logic [15:0] data_o;
    logic [15:0] data_i;
    logic        rd_wr_i;
    logic        led_o;

    int n_cmp = 0;
    int n_err = 0;

    led_sequencer #(.BaseAddress(0), .address_width(15), .data_width(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .address_i(address_i), .data_o(data_o),
        .data_i(data_i), .rd_wr_i(rd_wr_i), .led_o(led_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        address_i = a;
        data_i    = d;
        rd_wr_i   = 1'b1;
        @(negedge clk_i);
        rd_wr_i   = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a, output logic [15:0] d);
        address_i = a;
        rd_wr_i   = 1'b0;
        #1;
        d = data_o;
    endtask

    logic [15:0] r;
    int          ones;
    logic        t2_exp[12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic        t3_exp[8]  = '{1, 0, 0, 1, 0, 1, 0, 1};

    initial begin
        vt[0] = '{15'd0, 16'h0003, 16'h0003};
        vt[1] = '{15'd0, 16'hFFF8, 16'h0000};
        vt[2] = '{15'd1, 16'h1234, 16'h1234};
        vt[3] = '{15'd2, 16'hA5A5, 16'hA5A5};
        vt[4] = '{15'd3, 16'hFFFF, 16'h001F};
        vt[5] = '{15'd4, 16'hFFFF, 16'h0000};
        vt[6] = '{15'd5, 16'h0055, 16'h0000};
        vt[7] = '{15'd0, 16'h0002, 16'h0002};

        reset_i = 1'b1; address_i = '0; data_i = '0; rd_wr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        chk("reset_led", {15'd0, led_o}, 16'h0);
        for (int a = 0; a < 5; a++) begin
            rd(15'(a), r);
            chk($sformatf("reset_reg%0d", a), r, 16'h0);
        end

        // Register table
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, r);
            chk($sformatf("regvec%0d", i), r, vt[i].exp);
        end

        // T1: reset mid-run
        @(negedge clk_i);
        wr(15'd2, 16'hFFFF); wr(15'd3, 16'h0000); wr(15'd1, 16'h0000); wr(15'd0, 16'h0005);
        repeat (3) @(negedge clk_i);
        chk("t1_running_led", {15'd0, led_o}, 16'h1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("t1_led", {15'd0, led_o}, 16'h0);
        for (int a = 0; a < 5; a++) begin
            rd(15'(a), r);
            chk($sformatf("t1_reg%0d", a), r, 16'h0);
        end

        // T2: one-shot, 4 bits of 0x5, 3 clocks each
        @(negedge clk_i);
        wr(15'd2, 16'h0005); wr(15'd3, 16'h0004); wr(15'd1, 16'h0002); wr(15'd0, 16'h0007);
        chk("t2_led1", {15'd0, led_o}, {15'd0, t2_exp[0]});
        rd(15'd4, r); chk("t2_status_run", r, 16'h1);
        rd(15'd0, r); chk("t2_ctrl_rd", r, 16'h3);
        for (int k = 1; k < 12; k++) begin
            @(negedge clk_i);
            chk($sformatf("t2_led%0d", k + 1), {15'd0, led_o}, {15'd0, t2_exp[k]});
        end
        @(negedge clk_i);
        chk("t2_led13", {15'd0, led_o}, 16'h0);
        rd(15'd4, r); chk("t2_status_done", r, 16'h2);
        @(negedge clk_i);
        rd(15'd4, r); chk("t2_status_sticky", r, 16'h2);

        // T3: repeat with a PATTERN write that only lands at the wrap
        wr(15'd2, 16'h0001); wr(15'd3, 16'h0002); wr(15'd1, 16'h0000); wr(15'd0, 16'h0005);
        chk("t3_led1", {15'd0, led_o}, {15'd0, t3_exp[0]});
        wr(15'd2, 16'h0002);
        chk("t3_led2", {15'd0, led_o}, {15'd0, t3_exp[1]});
        for (int k = 2; k < 8; k++) begin
            @(negedge clk_i);
            chk($sformatf("t3_led%0d", k + 1), {15'd0, led_o}, {15'd0, t3_exp[k]});
        end

        // T4: disable mid one-shot run
        @(negedge clk_i);
        wr(15'd2, 16'hFFFF); wr(15'd3, 16'h0000); wr(15'd1, 16'h0000); wr(15'd0, 16'h0007);
        repeat (3) @(negedge clk_i);
        chk("t4_led_before", {15'd0, led_o}, 16'h1);
        wr(15'd0, 16'h0000);
        chk("t4_led_off", {15'd0, led_o}, 16'h0);
        rd(15'd4, r); chk("t4_status_off", r, 16'h0);
        repeat (20) @(negedge clk_i);
        rd(15'd4, r); chk("t4_never_done", r, 16'h0);

        // T5: DIV shrink while presc is at 50
        wr(15'd2, 16'h0002); wr(15'd3, 16'h0002); wr(15'd1, 16'd100); wr(15'd0, 16'h0007);
        repeat (50) @(negedge clk_i);
        wr(15'd1, 16'h0001);
        chk("t5_led_still0", {15'd0, led_o}, 16'h0);
        @(negedge clk_i);
        chk("t5_led_adv", {15'd0, led_o}, 16'h1);
        @(negedge clk_i);
        chk("t5_led_hold", {15'd0, led_o}, 16'h1);
        @(negedge clk_i);
        chk("t5_led_end", {15'd0, led_o}, 16'h0);
        rd(15'd4, r); chk("t5_status_done", r, 16'h2);

        // T6: LENGTH clamp for 0 and 31
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk_i);
            wr(15'd2, 16'hFFFF); wr(15'd3, pass == 0 ? 16'd0 : 16'd31);
            wr(15'd1, 16'h0000); wr(15'd0, 16'h0007);
            ones = 0;
            for (int k = 0; k < 16; k++) begin
                if (led_o) ones++;
                @(negedge clk_i);
            end
            chk($sformatf("t6_ones_p%0d", pass), 16'(ones), 16'd16);
            chk($sformatf("t6_led_end_p%0d", pass), {15'd0, led_o}, 16'h0);
            rd(15'd4, r); chk($sformatf("t6_status_p%0d", pass), r, 16'h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
